// File: rtl/fnd_pkg.sv
// Shared definitions for the 7-segment scan receive path: segment patterns,
// special digit codes, FSM states and a BCD helper.
package fnd_pkg;

    // Segment patterns, bit6 = a ... bit0 = g, active-high after normalization
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_INV   = 4'hE;

    typedef enum logic [1:0] {
        ALIGN   = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } fnd_state_t;

    // Tens/ones pair to binary; callers guarantee tens <= 5 so 6 bits never overflow
    function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return 6'(tens) * 6'd10 + 6'(ones);
    endfunction

endpackage

// File: rtl/fnd_seg2num.sv
// Segment pattern to digit code: 0-9, blank (all segments off) or invalid.
module fnd_seg2num
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       invalid
);

    // Table lookup; anything outside the ten digits and blank is invalid
    always_comb begin
        code    = DIG_INV;
        invalid = 1'b0;
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            SEG_OFF: code = DIG_BLANK;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receive-side monitor for a six-digit multiplexed 7-segment scan bus.
// Synchronizes the bus, waits for each digit to settle, decodes it and
// assembles hh:mm:ss frames with BCD/binary outputs and status strobes.
//
// Strobe semantics: o_frame_valid and o_err are single-cycle pulses with no
// back-pressure; o_time_valid and o_timeout are levels held until changed.
module fnd_scan_rx
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int FRAME_TO    = 50000,
    parameter int ENB_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_seg_enb,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    output logic [23:0] o_digit,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_hour,
    output logic [5:0]  o_min,
    output logic [5:0]  o_sec,
    output logic        o_time_valid,
    output logic        o_frame_valid,
    output logic        o_err,
    output logic        o_timeout
);

    localparam logic [3:0]  SETTLE_MAX = 4'(SETTLE_CYC);
    localparam logic [3:0]  CAP_AT     = 4'(SETTLE_CYC - 1);
    localparam logic [15:0] TO_MAX     = 16'(FRAME_TO);
    localparam logic [15:0] TO_LAST    = 16'(FRAME_TO - 1);

    logic [13:0] raw_vec, sync1, sync2, prev_vec;
    logic [3:0]  settle_cnt;
    logic [15:0] to_cnt;
    logic        cap, cap_none, cap_one, store, err_ev, timeout_ev, commit;
    logic [5:0]  cap_enb;
    logic [6:0]  cap_seg;
    logic [2:0]  slot;
    logic [3:0]  code;
    logic        invalid;
    fnd_state_t  state, state_nxt;
    logic [5:0]  seen, seen_nxt;
    logic [5:0][3:0] stage_dig;
    logic [5:0]  stage_dp;
    logic        time_ok;

    // Active-high view of the bus: {enables, segments, dp}
    assign raw_vec = {((ENB_ACT_LOW != 0) ? ~i_seg_enb : i_seg_enb),
                      ((SEG_ACT_LOW != 0) ? ~{i_seg, i_seg_dp} : {i_seg, i_seg_dp})};

    // Two-flop synchronizer plus a one-cycle-old copy for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev_vec <= '0;
        end else begin
            sync1    <= raw_vec;
            sync2    <= sync1;
            prev_vec <= sync2;
        end
    end

    // Settle counter: saturates so each stable interval yields exactly one event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) settle_cnt <= '0;
        else if (sync2 != prev_vec) settle_cnt <= '0;
        else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 4'd1;
    end

    // prev_vec holds the value that has been stable while the count built up
    assign cap      = (settle_cnt == CAP_AT);
    assign cap_enb  = prev_vec[13:8];
    assign cap_seg  = prev_vec[7:1];
    assign cap_none = (cap_enb == 6'h00);
    assign cap_one  = !cap_none && ((cap_enb & (cap_enb - 6'd1)) == 6'h00);
    assign store    = cap && cap_one;
    assign err_ev   = cap && ((!cap_none && !cap_one) || (cap_one && invalid));
    // A settle event of any kind counts as scan activity
    assign timeout_ev = !cap && (to_cnt == TO_LAST);

    fnd_seg2num u_seg2num (
        .seg     (cap_seg),
        .code    (code),
        .invalid (invalid)
    );

    // Slot index of the single active enable
    always_comb begin
        slot = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (cap_enb[i]) slot = 3'(i);
        end
    end

    // Stall watchdog: restarts on every settle event, saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            o_timeout <= 1'b0;
        end else if (cap) begin
            to_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 16'd1;
            if (timeout_ev) o_timeout <= 1'b1;
        end
    end

    // FSM state and seen mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALIGN;
            seen  <= '0;
        end else begin
            state <= state_nxt;
            seen  <= seen_nxt;
        end
    end

    // Next state: align on hour-tens, collect all six slots, commit for one cycle
    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        commit    = 1'b0;
        case (state)
            ALIGN: begin
                if (store && slot == 3'd5) begin
                    seen_nxt  = 6'b100000;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (store) seen_nxt = seen | cap_enb;
                if (seen_nxt == 6'h3F) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                seen_nxt  = store ? cap_enb : 6'h00;
                state_nxt = COLLECT;
            end
            default: state_nxt = ALIGN;
        endcase
        if (timeout_ev) begin
            seen_nxt  = 6'h00;
            state_nxt = ALIGN;
        end
    end

    // Staging registers: latest capture per slot wins; non-hour captures dropped while aligning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_dig <= {6{DIG_BLANK}};
            stage_dp  <= '0;
        end else if (store && (state != ALIGN || slot == 3'd5)) begin
            stage_dig[slot] <= code;
            stage_dp[slot]  <= prev_vec[0];
        end
    end

    // Legal time: all decimal digits, hour <= 23, minute and second tens <= 5
    always_comb begin
        time_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (stage_dig[i] > 4'd9) time_ok = 1'b0;
        end
        if (stage_dig[5] > 4'd2) time_ok = 1'b0;
        if (stage_dig[5] == 4'd2 && stage_dig[4] > 4'd3) time_ok = 1'b0;
        if (stage_dig[3] > 4'd5) time_ok = 1'b0;
        if (stage_dig[1] > 4'd5) time_ok = 1'b0;
    end

    // Frame outputs load on commit; binary time only updates when legal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_digit       <= {6{DIG_BLANK}};
            o_dp          <= '0;
            o_hour        <= '0;
            o_min         <= '0;
            o_sec         <= '0;
            o_time_valid  <= 1'b0;
            o_frame_valid <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_frame_valid <= commit;
            o_err         <= err_ev;
            if (commit) begin
                o_digit      <= stage_dig;
                o_dp         <= stage_dp;
                o_time_valid <= time_ok;
                if (time_ok) begin
                    o_hour <= bcd2bin(stage_dig[5], stage_dig[4]);
                    o_min  <= bcd2bin(stage_dig[3], stage_dig[2]);
                    o_sec  <= bcd2bin(stage_dig[1], stage_dig[0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: directed scans plus random frames, checked every
// cycle against a run-length/queue model of the scan receiver.
module tb_fnd_scan_rx;

    localparam int SETTLE   = 4;
    localparam int FRAME_TO = 300;
    // Settle event to visible effect: two sync stages plus the registered capture
    localparam int EV_LAT   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  seg_enb;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [23:0] o_digit;
    logic [5:0]  o_dp, o_hour, o_min, o_sec;
    logic        o_time_valid, o_frame_valid, o_err, o_timeout;

    fnd_scan_rx #(
        .SETTLE_CYC  (SETTLE),
        .FRAME_TO    (FRAME_TO),
        .ENB_ACT_LOW (1),
        .SEG_ACT_LOW (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_seg_enb     (seg_enb),
        .i_seg         (seg),
        .i_seg_dp      (seg_dp),
        .o_digit       (o_digit),
        .o_dp          (o_dp),
        .o_hour        (o_hour),
        .o_min         (o_min),
        .o_sec         (o_sec),
        .o_time_valid  (o_time_valid),
        .o_frame_valid (o_frame_valid),
        .o_err         (o_err),
        .o_timeout     (o_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int dut_frames = 0;
    int dut_errs   = 0;

    logic [6:0] pat_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // ---------------- reference model ----------------
    logic [13:0] run_val;
    int          run_len;
    logic [13:0] ev_q[$];
    int          ev_due[$];
    int          edge_no;
    logic [3:0]  m_stage [6];
    logic        m_sdp [6];
    logic [5:0]  m_seen;
    bit          m_align, m_commit_pend;
    int          m_tcnt;
    logic [23:0] e_digit;
    logic [5:0]  e_dp, e_hour, e_min, e_sec;
    logic        e_tv, e_fv, e_err, e_to;

    function automatic logic [3:0] decode(input logic [6:0] p);
        if (p == 7'h00) return 4'hF;
        for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return 4'(i);
        return 4'hE;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        if (d <= 4'd9) return pat_tab[d];
        if (d == 4'hF) return 7'h00;
        return 7'h01;
    endfunction

    function automatic void model_reset();
        // Synchronizer stages come out of reset holding the idle vector
        run_val = '0; run_len = EV_LAT; edge_no = 0;
        ev_q.delete(); ev_due.delete();
        for (int i = 0; i < 6; i++) begin m_stage[i] = 4'hF; m_sdp[i] = 1'b0; end
        m_seen = '0; m_align = 1; m_commit_pend = 0; m_tcnt = 0;
        e_digit = 24'hFFFFFF; e_dp = '0; e_hour = '0; e_min = '0; e_sec = '0;
        e_tv = 0; e_fv = 0; e_err = 0; e_to = 0;
    endfunction

    function automatic void do_commit();
        int h, m, s;
        bit ok;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            e_digit[i*4 +: 4] = m_stage[i];
            e_dp[i] = m_sdp[i];
            if (m_stage[i] > 9) ok = 0;
        end
        h = int'(m_stage[5]) * 10 + int'(m_stage[4]);
        m = int'(m_stage[3]) * 10 + int'(m_stage[2]);
        s = int'(m_stage[1]) * 10 + int'(m_stage[0]);
        if (h > 23 || m > 59 || s > 59) ok = 0;
        e_fv = 1;
        e_tv = ok;
        if (ok) begin e_hour = 6'(h); e_min = 6'(m); e_sec = 6'(s); end
        m_seen = '0;
    endfunction

    function automatic void handle_event(input logic [13:0] d);
        logic [5:0] enb;
        logic [3:0] c;
        int slot;
        enb = d[13:8];
        if ($countones(enb) == 0) return;
        if ($countones(enb) > 1) begin e_err = 1; return; end
        slot = 0;
        for (int i = 0; i < 6; i++) if (enb[i]) slot = i;
        c = decode(d[7:1]);
        if (c == 4'hE) e_err = 1;
        if (m_align && slot != 5) return;
        m_align = 0;
        m_stage[slot] = c;
        m_sdp[slot] = d[0];
        m_seen[slot] = 1'b1;
        if (m_seen == 6'h3F) m_commit_pend = 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [13:0] cur;
            bit          got;
            edge_no++;
            e_fv = 0; e_err = 0;
            if (m_commit_pend) begin m_commit_pend = 0; do_commit(); end
            cur = {~seg_enb, seg, seg_dp};
            if (cur == run_val) begin
                if (run_len < 100000) run_len++;
            end else begin
                run_val = cur; run_len = 1;
            end
            got = 0;
            if (ev_due.size() > 0 && ev_due[0] == edge_no) begin
                got = 1;
                void'(ev_due.pop_front());
                handle_event(ev_q.pop_front());
            end
            // A value held for SETTLE samples is reported once, EV_LAT edges later
            if (run_len == SETTLE) begin
                ev_q.push_back(run_val);
                ev_due.push_back(edge_no + EV_LAT);
            end
            if (got) begin
                m_tcnt = 0; e_to = 0;
            end else if (m_tcnt < FRAME_TO) begin
                m_tcnt++;
                if (m_tcnt == FRAME_TO) begin e_to = 1; m_seen = '0; m_align = 1; end
            end
        end
    end

    // ---------------- scoreboard: every cycle out of reset ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [51:0] act, exp;
            act = {o_digit, o_dp, o_hour, o_min, o_sec, o_time_valid, o_frame_valid, o_err, o_timeout};
            exp = {e_digit, e_dp, e_hour, e_min, e_sec, e_tv, e_fv, e_err, e_to};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, act, exp);
            if (o_frame_valid) dut_frames++;
            if (o_err) dut_errs++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: dut=%0h expected=%0h", name, act, exp);
    endtask

    // ---------------- drivers ----------------
    // enb is the active-high slot mask; the bus itself uses active-low enables
    task automatic show(input logic [5:0] enb, input logic [6:0] pat, input logic dp, input int cyc);
        seg_enb = ~enb; seg = pat; seg_dp = dp;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan_range(input logic [23:0] dig, input int hi, input int lo,
                              input logic [5:0] dps);
        for (int s = hi; s >= lo; s--) begin
            show(6'(1 << s), enc(dig[s*4 +: 4]), dps[s], 20);
            show(6'h00, 7'h00, 1'b0, 2);
        end
    endtask

    task automatic scan(input logic [23:0] dig);
        scan_range(dig, 5, 0, 6'b010100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f0, e0;
        seg_enb = 6'h3F; seg = '0; seg_dp = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_digit", 32'(o_digit), 32'hFFFFFF);
        check("rst_tv", 32'(o_time_valid), 0);
        check("rst_hour", 32'(o_hour), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        show(6'h00, 7'h00, 1'b0, 10);

        scan(24'h123456);
        check("t1_digit", 32'(o_digit), 32'h123456);
        check("t1_model_digit", 32'(e_digit), 32'h123456);
        check("t1_hour", 32'(o_hour), 12);
        check("t1_min", 32'(o_min), 34);
        check("t1_sec", 32'(o_sec), 56);
        check("t1_tv", 32'(o_time_valid), 1);
        check("t1_dp", 32'(o_dp), 32'b010100);
        check("t1_frames", 32'(dut_frames), 1);

        scan(24'h235959);
        check("t2_hour", 32'(o_hour), 23);
        scan(24'h000000);
        check("t2_digit", 32'(o_digit), 32'h000000);
        check("t2_bin", 32'({o_hour, o_min, o_sec}), 0);
        check("t2_tv", 32'(o_time_valid), 1);

        scan(24'h123456);
        scan(24'hFF3456);
        check("blank_digit", 32'(o_digit), 32'hFF3456);
        check("blank_tv", 32'(o_time_valid), 0);
        check("blank_bin", 32'({o_hour, o_min, o_sec}), {14'd0, 6'd12, 6'd34, 6'd56});

        e0 = dut_errs;
        scan_range(24'h123451, 5, 1, 6'h00);
        show(6'b000001, 7'h7F, 1'b0, SETTLE - 2);
        show(6'b000001, 7'h30, 1'b0, 20);
        show(6'h00, 7'h00, 1'b0, 2);
        check("glitch_digit", 32'(o_digit), 32'h123451);
        check("glitch_noerr", 32'(dut_errs), 32'(e0));

        scan_range(24'h123450, 5, 1, 6'h00);
        show(6'b000001, 7'h01, 1'b0, 10);
        show(6'h00, 7'h00, 1'b0, 2);
        check("inv_err", 32'(dut_errs), 32'(e0 + 1));
        check("inv_digit", 32'(o_digit), 32'h12345E);
        check("inv_tv", 32'(o_time_valid), 0);

        f0 = dut_frames; e0 = dut_errs;
        scan_range(24'h102030, 5, 3, 6'h00);
        show(6'b110111, 7'h30, 1'b0, 12);
        show(6'h00, 7'h00, 1'b0, 2);
        check("multi_err", 32'(dut_errs), 32'(e0 + 1));
        check("multi_noframe", 32'(dut_frames), 32'(f0));
        scan(24'h102030);
        check("multi_resume", 32'(dut_frames), 32'(f0 + 1));
        check("multi_digit", 32'(o_digit), 32'h102030);

        f0 = dut_frames;
        scan_range(24'h010203, 5, 4, 6'h00);
        show(6'b001000, enc(4'd2), 1'b0, FRAME_TO + 20);
        check("to_set", 32'(o_timeout), 1);
        check("to_hold_digit", 32'(o_digit), 32'h102030);
        show(6'b010000, enc(4'd7), 1'b0, 20);
        check("to_clear", 32'(o_timeout), 0);
        show(6'h00, 7'h00, 1'b0, 2);
        scan_range(24'h999999, 3, 0, 6'h00);
        check("to_align_ignore", 32'(dut_frames), 32'(f0));
        scan(24'h214500);
        check("to_realign", 32'(dut_frames), 32'(f0 + 1));
        check("to_digit", 32'(o_digit), 32'h214500);

        for (int f = 0; f < 30; f++) begin
            logic [23:0] d;
            int h, m, s, r;
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 6; k++) begin
                    r = $urandom_range(0, 11);
                    d[k*4 +: 4] = (r < 10) ? 4'(r) : ((r == 10) ? 4'hF : 4'hE);
                end
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
                d = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
            end
            for (int k = 5; k >= 0; k--) begin
                if ($urandom_range(0, 24) == 0)
                    show(6'b100001, pat_tab[$urandom_range(0, 9)], 1'b0, 8);
                show(6'(1 << k), enc(d[k*4 +: 4]), 1'($urandom_range(0, 1)), $urandom_range(3, 24));
                r = $urandom_range(0, 3);
                if (r > 0) show(6'h00, 7'h00, 1'b0, r);
            end
        end

        scan_range(24'h123456, 5, 3, 6'h00);
        show(6'b000100, enc(4'd4), 1'b0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digit", 32'(o_digit), 32'hFFFFFF);
        check("arst_flags", 32'({o_time_valid, o_frame_valid, o_err, o_timeout}), 0);
        check("arst_bin", 32'({o_hour, o_min, o_sec, o_dp}), 0);
        @(negedge clk);
        show(6'h00, 7'h00, 1'b0, 3);
        rst_n = 1'b1;
        show(6'h00, 7'h00, 1'b0, 10);
        scan(24'h075959);
        check("post_rst_hour", 32'(o_hour), 7);
        check("post_rst_digit", 32'(o_digit), 32'h075959);
        check("post_rst_tv", 32'(o_time_valid), 1);

        show(6'h00, 7'h00, 1'b0, 20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
